// File: rtl/shift_align_lock.sv
// shift_align_lock
// ----------------
// Sync-word aligner between the deserialiser lane bank and the frame decoder.
// Hunts every lane for SYNC at any bit offset, verifies it over LOCK_CNT
// sync slots, then streams bit-aligned words from the chosen lane. Lock is
// dropped after LOSS_CNT consecutive sync-slot misses or STALL_MAX idle cycles.
//
// Ports:
//   clk         clock, all logic on posedge
//   rst         asynchronous active-high reset
//   valid_in    per-lane word valid
//   datain      lane i word at [i*W+W-1 : i*W]
//   dataout     aligned word (holds when valid is low)
//   valid       dataout qualifier
//   locked      high while in LOCKED
//   lane_sel    selected lane
//   bit_offset  selected bit offset
//   err_cnt     saturating count of sync-slot misses while LOCKED
//   state_dbg   FSM state: 0 = HUNT, 1 = VERIFY, 2 = LOCKED
//
// Handshake: valid_in[i] qualifies lane i's word for that single cycle and
// there is no backpressure; valid qualifies dataout for exactly one cycle.
module shift_align_lock #(
    parameter int           LANES       = 16,
    parameter int           W           = 16,
    parameter logic [W-1:0] SYNC        = 16'h817E,
    parameter int           SYNC_PERIOD = 1,
    parameter int           LOCK_CNT    = 3,
    parameter int           LOSS_CNT    = 4,
    parameter int           STALL_MAX   = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LANES-1:0]         valid_in,
    input  logic [LANES*W-1:0]       datain,
    output logic [W-1:0]             dataout,
    output logic                     valid,
    output logic                     locked,
    output logic [$clog2(LANES)-1:0] lane_sel,
    output logic [$clog2(W)-1:0]     bit_offset,
    output logic [15:0]              err_cnt,
    output logic [1:0]               state_dbg
);
    localparam int LW = $clog2(LANES);
    localparam int OW = $clog2(W);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t state, state_n;

    logic [W-1:0]     prev [LANES];
    logic [LANES-1:0] hist_ok;
    logic [2*W-1:0]   win  [LANES];

    logic [15:0] match_cnt, match_n;
    logic [15:0] slot, slot_n, slot_adv;
    logic [15:0] miss_cnt, miss_n;
    logic [15:0] stall_cnt, stall_n;
    logic [15:0] err_n;
    logic [W-1:0] dout_n;
    logic         valid_n;
    logic [LW-1:0] sel_n;
    logic [OW-1:0] off_n;

    // Two-word window per lane, previous word in the upper half.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            win[i] = {prev[i], datain[i*W +: W]};
        end
    end

    // Hunt scan: descending loops so the last overwrite is the lowest lane,
    // then the lowest offset. Offsets above 0 need a stored previous word.
    logic          hit;
    logic [LW-1:0] hit_lane;
    logic [OW-1:0] hit_off;

    always_comb begin
        hit      = 1'b0;
        hit_lane = '0;
        hit_off  = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            for (int k = W - 1; k >= 0; k--) begin
                if (valid_in[i] && (k == 0 || hist_ok[i]) && win[i][k +: W] == SYNC) begin
                    hit      = 1'b1;
                    hit_lane = LW'(i);
                    hit_off  = OW'(k);
                end
            end
        end
    end

    logic [2*W-1:0] sel_win;
    logic [W-1:0]   sel_cand;
    logic           sel_valid;
    logic           sync_slot;
    logic           sync_ok;

    assign sel_win   = win[lane_sel];
    assign sel_cand  = sel_win[bit_offset +: W];
    assign sel_valid = valid_in[lane_sel];
    assign sync_slot = (slot == 16'd0);
    assign sync_ok   = (sel_cand == SYNC);
    assign slot_adv  = (slot == 16'(SYNC_PERIOD - 1)) ? 16'd0 : slot + 16'd1;

    always_comb begin
        state_n = state;
        sel_n   = lane_sel;
        off_n   = bit_offset;
        match_n = match_cnt;
        slot_n  = slot;
        miss_n  = miss_cnt;
        stall_n = stall_cnt;
        err_n   = err_cnt;
        dout_n  = dataout;
        valid_n = 1'b0;
        case (state)
            HUNT: begin
                if (hit) begin
                    sel_n   = hit_lane;
                    off_n   = hit_off;
                    match_n = 16'd1;
                    slot_n  = 16'(1 % SYNC_PERIOD);
                    miss_n  = 16'd0;
                    stall_n = 16'd0;
                    state_n = (LOCK_CNT == 1) ? LOCKED : VERIFY;
                end
            end
            VERIFY: begin
                if (sel_valid) begin
                    stall_n = 16'd0;
                    slot_n  = slot_adv;
                    if (sync_slot) begin
                        if (sync_ok) begin
                            match_n = match_cnt + 16'd1;
                            if (match_cnt + 16'd1 == 16'(LOCK_CNT)) begin
                                state_n = LOCKED;
                                miss_n  = 16'd0;
                            end
                        end else begin
                            match_n = 16'd0;
                            state_n = HUNT;
                        end
                    end
                end else if (stall_cnt == 16'(STALL_MAX - 1)) begin
                    stall_n = 16'd0;
                    match_n = 16'd0;
                    state_n = HUNT;
                end else begin
                    stall_n = stall_cnt + 16'd1;
                end
            end
            LOCKED: begin
                // A valid word and a stall expiry cannot coincide, so loss and
                // stall never both fire on one edge.
                if (sel_valid) begin
                    stall_n = 16'd0;
                    slot_n  = slot_adv;
                    dout_n  = sel_cand;
                    valid_n = 1'b1;
                    if (sync_slot) begin
                        if (sync_ok) begin
                            miss_n = 16'd0;
                        end else begin
                            miss_n = miss_cnt + 16'd1;
                            if (err_cnt != 16'hFFFF) begin
                                err_n = err_cnt + 16'd1;
                            end
                            if (miss_cnt + 16'd1 == 16'(LOSS_CNT)) begin
                                miss_n  = 16'd0;
                                match_n = 16'd0;
                                state_n = HUNT;
                            end
                        end
                    end
                end else if (stall_cnt == 16'(STALL_MAX - 1)) begin
                    stall_n = 16'd0;
                    miss_n  = 16'd0;
                    match_n = 16'd0;
                    state_n = HUNT;
                end else begin
                    stall_n = stall_cnt + 16'd1;
                end
            end
            default: state_n = HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dataout    <= '0;
            valid      <= 1'b0;
            lane_sel   <= '0;
            bit_offset <= '0;
            err_cnt    <= '0;
            match_cnt  <= '0;
            slot       <= '0;
            miss_cnt   <= '0;
            stall_cnt  <= '0;
            hist_ok    <= '0;
            for (int i = 0; i < LANES; i++) begin
                prev[i] <= '0;
            end
        end else begin
            dataout    <= dout_n;
            valid      <= valid_n;
            lane_sel   <= sel_n;
            bit_offset <= off_n;
            err_cnt    <= err_n;
            match_cnt  <= match_n;
            slot       <= slot_n;
            miss_cnt   <= miss_n;
            stall_cnt  <= stall_n;
            for (int i = 0; i < LANES; i++) begin
                if (valid_in[i]) begin
                    prev[i]    <= datain[i*W +: W];
                    hist_ok[i] <= 1'b1;
                end
            end
        end
    end

    assign locked    = (state == LOCKED);
    assign state_dbg = state;

endmodule

// File: tb/tb_shift_align_lock.sv
module tb_shift_align_lock;
  localparam logic [15:0] SYNC = 16'h817E;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [15:0]  vin0 = '0, vin1 = '0;
  logic [255:0] din0 = '0, din1 = '0;
  logic [15:0]  dout0, dout1, err0, err1;
  logic         valid0, valid1, locked0, locked1;
  logic [3:0]   sel0, sel1, off0, off1;
  logic [1:0]   st0, st1;

  int checks = 0;
  int errors = 0;

  shift_align_lock dut (
    .clk(clk), .rst(rst), .valid_in(vin0), .datain(din0),
    .dataout(dout0), .valid(valid0), .locked(locked0), .lane_sel(sel0),
    .bit_offset(off0), .err_cnt(err0), .state_dbg(st0)
  );

  shift_align_lock #(.SYNC_PERIOD(4)) dut_p4 (
    .clk(clk), .rst(rst), .valid_in(vin1), .datain(din1),
    .dataout(dout1), .valid(valid1), .locked(locked1), .lane_sel(sel1),
    .bit_offset(off1), .err_cnt(err1), .state_dbg(st1)
  );

  // Reference model: mode 0 = hunting, 1 = verifying, 2 = locked.
  int          period [2] = '{1, 4};
  int          e_mode [2], e_sel [2], e_off [2], e_match [2];
  int          e_slot [2], e_miss [2], e_stall [2], e_err [2];
  logic [15:0] e_dout [2];
  bit          e_valid [2];
  logic [15:0] m_prev [2][16];
  bit          m_hist [2][16];

  function automatic logic [15:0] cand(input logic [15:0] p, input logic [15:0] c, input int k);
    logic [31:0] w;
    w = {p, c} >> k;
    return w[15:0];
  endfunction

  function automatic logic [15:0] rotl(input logic [15:0] x, input int r);
    logic [31:0] t;
    t = {x, x} << r;
    return t[31:16];
  endfunction

  task automatic model_reset(input int m);
    e_mode[m] = 0; e_sel[m] = 0; e_off[m] = 0; e_match[m] = 0;
    e_slot[m] = 0; e_miss[m] = 0; e_stall[m] = 0; e_err[m] = 0;
    e_dout[m] = '0; e_valid[m] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      m_prev[m][i] = '0;
      m_hist[m][i] = 1'b0;
    end
  endtask

  task automatic model_step(input int m, input logic [15:0] v, input logic [255:0] d);
    logic [15:0] cur [16];
    logic [15:0] c;
    bit found;
    bit sync_slot;
    int s;
    found = 1'b0;
    for (int i = 0; i < 16; i++) cur[i] = d[i*16 +: 16];
    e_valid[m] = 1'b0;
    s = e_sel[m];
    if (e_mode[m] == 0) begin
      for (int i = 0; i < 16; i++) begin
        for (int k = 0; k < 16; k++) begin
          if (!found && v[i] && (k == 0 || m_hist[m][i]) && cand(m_prev[m][i], cur[i], k) == SYNC) begin
            found = 1'b1;
            e_sel[m] = i; e_off[m] = k; e_match[m] = 1;
            e_slot[m] = 1 % period[m]; e_miss[m] = 0; e_stall[m] = 0;
            e_mode[m] = 1;
          end
        end
      end
    end else if (v[s]) begin
      c = cand(m_prev[m][s], cur[s], e_off[m]);
      sync_slot = (e_slot[m] == 0);
      e_slot[m] = (e_slot[m] + 1) % period[m];
      e_stall[m] = 0;
      if (e_mode[m] == 2) begin
        e_dout[m] = c;
        e_valid[m] = 1'b1;
      end
      if (sync_slot) begin
        if (e_mode[m] == 1) begin
          if (c == SYNC) begin
            e_match[m]++;
            if (e_match[m] == 3) begin
              e_mode[m] = 2;
              e_miss[m] = 0;
            end
          end else begin
            e_mode[m] = 0;
          end
        end else if (c == SYNC) begin
          e_miss[m] = 0;
        end else begin
          e_miss[m]++;
          if (e_err[m] < 65535) e_err[m]++;
          if (e_miss[m] == 4) e_mode[m] = 0;
        end
      end
    end else begin
      e_stall[m]++;
      if (e_stall[m] == 64) e_mode[m] = 0;
    end
    for (int i = 0; i < 16; i++) begin
      if (v[i]) begin
        m_prev[m][i] = cur[i];
        m_hist[m][i] = 1'b1;
      end
    end
  endtask

  function automatic logic [41:0] obs_vec(input int m);
    if (m == 0) return {locked0, valid0, sel0, off0, err0, dout0};
    return {locked1, valid1, sel1, off1, err1, dout1};
  endfunction

  function automatic logic [41:0] exp_vec(input int m);
    return {e_mode[m] == 2, e_valid[m], 4'(e_sel[m]), 4'(e_off[m]), 16'(e_err[m]), e_dout[m]};
  endfunction

  // Clock/reset and driver tasks
  task automatic tick();
    @(posedge clk);
    model_step(0, vin0, din0);
    model_step(1, vin1, din1);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset(0);
    model_reset(1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_inputs();
    vin0 = '0; vin1 = '0;
    din0 = {8{$urandom()}};
    din1 = {8{$urandom()}};
  endtask

  task automatic set_lane(input int m, input int i, input bit v, input logic [15:0] w);
    if (m == 0) begin
      vin0[i] = v; din0[i*16 +: 16] = w;
    end else begin
      vin1[i] = v; din1[i*16 +: 16] = w;
    end
  endtask

  // Tests
  task automatic test_reset();
    clear_inputs();
    do_reset();
    checks++;
    if (obs_vec(0) !== 42'd0 || st0 !== 2'd0) begin
      errors++; $display("FAIL reset_dut got %h st %0d want 0", obs_vec(0), st0);
    end
    checks++;
    if (obs_vec(1) !== 42'd0 || st1 !== 2'd0) begin
      errors++; $display("FAIL reset_dut_p4 got %h st %0d want 0", obs_vec(1), st1);
    end
  endtask

  task automatic test_lock_basic();
    clear_inputs();
    set_lane(0, 1, 1'b1, SYNC);
    set_lane(0, 3, 1'b1, SYNC);
    for (int c = 1; c <= 6; c++) begin
      tick();
      checks++;
      if (obs_vec(0) !== exp_vec(0)) begin
        errors++; $display("FAIL lock_basic_model cyc%0d got %h want %h", c, obs_vec(0), exp_vec(0));
      end
      if (c == 1) begin
        checks++;
        if (sel0 !== 4'd1 || off0 !== 4'd0) begin
          errors++; $display("FAIL lock_basic_sel got lane %0d off %0d want lane 1 off 0", sel0, off0);
        end
      end
      if (c == 2 || c == 3) begin
        checks++;
        if (locked0 !== (c == 3) || valid0 !== 1'b0) begin
          errors++; $display("FAIL lock_basic_lock cyc%0d got locked %b valid %b", c, locked0, valid0);
        end
      end
      if (c >= 4) begin
        checks++;
        if (valid0 !== 1'b1 || dout0 !== SYNC) begin
          errors++; $display("FAIL lock_basic_out cyc%0d got valid %b data %h want 1 817e", c, valid0, dout0);
        end
      end
    end
  endtask

  task automatic test_loss();
    set_lane(0, 1, 1'b1, 16'hAAAA);
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (obs_vec(0) !== exp_vec(0)) begin
        errors++; $display("FAIL loss_model cyc%0d got %h want %h", c, obs_vec(0), exp_vec(0));
      end
      checks++;
      if (err0 !== 16'(c) || locked0 !== (c < 4) || valid0 !== 1'b1 || dout0 !== 16'hAAAA) begin
        errors++; $display("FAIL loss_count cyc%0d got err %0d locked %b valid %b data %h", c, err0, locked0, valid0, dout0);
      end
    end
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if (obs_vec(0) !== exp_vec(0)) begin
        errors++; $display("FAIL relock_model cyc%0d got %h want %h", c, obs_vec(0), exp_vec(0));
      end
      checks++;
      if (sel0 !== 4'd3 || locked0 !== (c == 3) || err0 !== 16'd4) begin
        errors++; $display("FAIL relock cyc%0d got lane %0d locked %b err %0d want lane 3 err 4", c, sel0, locked0, err0);
      end
    end
  endtask

  task automatic test_stall();
    clear_inputs();
    do_reset();
    set_lane(0, 1, 1'b1, SYNC);
    repeat (4) tick();
    checks++;
    if (locked0 !== 1'b1 || valid0 !== 1'b1) begin
      errors++; $display("FAIL stall_prelock got locked %b valid %b want 1 1", locked0, valid0);
    end
    vin0 = '0;
    for (int c = 1; c <= 64; c++) begin
      tick();
      checks++;
      if (obs_vec(0) !== exp_vec(0)) begin
        errors++; $display("FAIL stall_model cyc%0d got %h want %h", c, obs_vec(0), exp_vec(0));
      end
      if (c == 63 || c == 64) begin
        checks++;
        if (locked0 !== (c == 63) || st0 !== ((c == 64) ? 2'd0 : 2'd2) || dout0 !== SYNC) begin
          errors++; $display("FAIL stall_drop cyc%0d got locked %b state %0d data %h", c, locked0, st0, dout0);
        end
      end
    end
  endtask

  task automatic test_offset();
    clear_inputs();
    do_reset();
    set_lane(0, 0, 1'b1, 16'h2FD0);
    for (int c = 1; c <= 6; c++) begin
      tick();
      checks++;
      if (obs_vec(0) !== exp_vec(0)) begin
        errors++; $display("FAIL offset_model cyc%0d got %h want %h", c, obs_vec(0), exp_vec(0));
      end
      if (c == 1) begin
        checks++;
        if (st0 !== 2'd0) begin
          errors++; $display("FAIL offset_nohit got state %0d want 0", st0);
        end
      end
      if (c == 2) begin
        checks++;
        if (off0 !== 4'd5 || sel0 !== 4'd0) begin
          errors++; $display("FAIL offset_hit got off %0d lane %0d want off 5 lane 0", off0, sel0);
        end
      end
      if (c >= 5) begin
        checks++;
        if (locked0 !== 1'b1 || valid0 !== 1'b1 || dout0 !== SYNC) begin
          errors++; $display("FAIL offset_out cyc%0d got locked %b valid %b data %h", c, locked0, valid0, dout0);
        end
      end
    end
  endtask

  task automatic test_period();
    logic [15:0] pat [4];
    logic [15:0] w;
    pat = '{16'h817E, 16'h0011, 16'h0022, 16'h0033};
    clear_inputs();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      w = (c == 16) ? 16'hDEAD : pat[c % 4];
      set_lane(1, 2, 1'b1, w);
      tick();
      checks++;
      if (obs_vec(1) !== exp_vec(1)) begin
        errors++; $display("FAIL period_model word%0d got %h want %h", c, obs_vec(1), exp_vec(1));
      end
      if (c == 7 || c == 8) begin
        checks++;
        if (locked1 !== (c == 8) || valid1 !== 1'b0) begin
          errors++; $display("FAIL period_lock word%0d got locked %b valid %b", c, locked1, valid1);
        end
      end
      if (c >= 9 && c <= 11) begin
        checks++;
        if (valid1 !== 1'b1 || dout1 !== pat[c % 4]) begin
          errors++; $display("FAIL period_payload word%0d got valid %b data %h want %h", c, valid1, dout1, pat[c % 4]);
        end
      end
    end
    checks++;
    if (err1 !== 16'd1 || locked1 !== 1'b1) begin
      errors++; $display("FAIL period_corrupt got err %0d locked %b want 1 1", err1, locked1);
    end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    do_reset();
    set_lane(0, 1, 1'b1, SYNC);
    set_lane(0, 3, 1'b1, SYNC);
    repeat (5) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (obs_vec(0) !== 42'd0 || st0 !== 2'd0) begin
      errors++; $display("FAIL reset_mid_clear got %h state %0d want 0", obs_vec(0), st0);
    end
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (obs_vec(0) !== exp_vec(0)) begin
        errors++; $display("FAIL reset_mid_model cyc%0d got %h want %h", c, obs_vec(0), exp_vec(0));
      end
    end
    checks++;
    if (locked0 !== 1'b1 || sel0 !== 4'd1 || dout0 !== SYNC || valid0 !== 1'b1) begin
      errors++; $display("FAIL reset_mid_relock got locked %b lane %0d data %h", locked0, sel0, dout0);
    end
  endtask

  task automatic test_random();
    int gl, r;
    bit v;
    logic [15:0] w;
    clear_inputs();
    do_reset();
    for (int seg = 0; seg < 5; seg++) begin
      gl = $urandom_range(0, 15);
      r  = $urandom_range(0, 15);
      for (int c = 0; c < 100; c++) begin
        for (int i = 0; i < 16; i++) begin
          if (i == gl) begin
            v = ($urandom_range(0, 9) < 8);
            w = ($urandom_range(0, 19) == 0) ? 16'($urandom()) : rotl(SYNC, r);
          end else begin
            v = ($urandom_range(0, 3) == 0);
            w = 16'($urandom());
          end
          set_lane(0, i, v, w);
          set_lane(1, i, v, w);
        end
        tick();
        checks++;
        if (obs_vec(0) !== exp_vec(0)) begin
          errors++; $display("FAIL random_p1 seg%0d cyc%0d got %h want %h", seg, c, obs_vec(0), exp_vec(0));
        end
        checks++;
        if (obs_vec(1) !== exp_vec(1)) begin
          errors++; $display("FAIL random_p4 seg%0d cyc%0d got %h want %h", seg, c, obs_vec(1), exp_vec(1));
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_lock_basic();
    test_loss();
    test_stall();
    test_offset();
    test_period();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_align_lock.md
Name: shift_align_lock

Overview:
- Parametrised successor to shift_align.
- Hunts all input lanes for a sync word at any bit offset. Selects one lane and offset, verifies the sync word over several occurrences, then declares lock.
- While locked, emits bit-aligned words from the selected lane. Monitors sync slots and drops lock on repeated misses or a stalled lane.
- Sits between the deserialiser lane bank and the frame decoder.

Parameters:
- LANES, 16, number of input lanes.
- W, 16, word width in bits.
- SYNC, 16'h817E, sync word (W bits).
- SYNC_PERIOD, 1, valid words per sync slot on the selected lane (1 = every word is sync).
- LOCK_CNT, 3, consecutive sync matches (including the hunt hit) needed to lock.
- LOSS_CNT, 4, consecutive sync-slot misses in LOCKED that drop lock.
- STALL_MAX, 64, clock cycles without a selected-lane valid (VERIFY/LOCKED) before returning to HUNT.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous active-high reset.
- valid_in  in  LANES  per-lane word valid.
- datain  in  LANES*W  lane i word at [i*W+W-1 : i*W].
- dataout  out  W  aligned word.
- valid  out  1  dataout qualifier.
- locked  out  1  high in LOCKED state.
- lane_sel  out  $clog2(LANES)  selected lane.
- bit_offset  out  $clog2(W)  selected bit offset.
- err_cnt  out  16  saturating count of sync-slot misses while LOCKED.

Behaviour:
- Reset (async, rst=1): state=HUNT. dataout, valid, locked, lane_sel, bit_offset and err_cnt = 0. Per-lane prev words = 0, hist_ok = 0, all counters = 0.
  - Reset mid-operation aborts immediately, with no output glitch beyond the async clear.
- Per-lane history: on each valid_in[i], prev_i <= current word and hist_ok_i <= 1.
- Window_i = {prev_i, cur_i}, 2W bits, prev in the upper half. Candidate at offset k (0..W-1) = window_i[k+W-1:k]. k=0 is always usable; k>0 requires hist_ok_i=1.
- HUNT:
  - Each cycle, scan every lane with valid_in=1 for candidate == SYNC. Priority: lowest lane, then lowest k.
  - On a hit: latch lane_sel and bit_offset, match_cnt=1, slot=1 mod SYNC_PERIOD, go to VERIFY. If LOCK_CNT=1, go directly to LOCKED instead.
  - valid=0 throughout HUNT.
- VERIFY:
  - Only valid words of the selected lane count; idle cycles are ignored.
  - At slot 0: match increments match_cnt; reaching LOCK_CNT moves to LOCKED. Mismatch returns to HUNT the next cycle and clears match_cnt.
  - Non-sync slots are not checked; slot advances mod SYNC_PERIOD on every selected valid word.
  - valid=0.
- LOCKED:
  - Every selected-lane valid word sampled at edge n drives dataout=candidate(bit_offset) and valid=1 at edge n+1 (1-cycle latency). Otherwise valid=0 and dataout holds.
  - Lock is declared at the edge of word index LOCK_CNT-1. The first output word is index LOCK_CNT.
  - Slot-0 mismatch: miss_cnt++, err_cnt++ (saturates at 16'hFFFF). Slot-0 match: miss_cnt=0.
  - miss_cnt reaching LOSS_CNT: go to HUNT. That word is still output; locked drops at the same edge.
- Stall: a cycle counter clears on each selected valid word. Reaching STALL_MAX in VERIFY or LOCKED forces HUNT.
- On entering HUNT: locked=0, lane_sel and bit_offset hold their last values, err_cnt holds (cleared only by reset). Hunting resumes on the very next cycle, using the lane history already stored.
- Simultaneous loss and stall at the same edge: go to HUNT once; err_cnt increments for the miss.

Test Plan:
- Lanes 1 and 3 = 16'h817E every cycle from reset release: lane_sel=1, bit_offset=0, locked after the 3rd word, valid=1 with dataout=16'h817E from the 4th word onward.
- Lane 0 constant 16'h2FD0 (SYNC rotated left by 5), all other lanes invalid: first word gives no hit; second word hits with bit_offset=5; dataout=16'h817E once locked.
- After the first test locks, lane 1 switches to 16'hAAAA while lane 3 stays 16'h817E: err_cnt counts 1..4 and locked drops at the 4th miss; on the next cycle lane_sel=3, and lock is re-gained 3 words later.
- SYNC_PERIOD=4, lane 2 sending 817E,11,22,33 repeating: locks after 3 sync words; payload 11,22,33 passes through with valid; corrupting one sync word bumps err_cnt by 1 and lock holds.
- Locked on lane 1, then valid_in[1]=0 for 64 cycles: locked=0 at cycle 64 and state returns to HUNT.
- Locked, then rst pulsed mid-stream: all outputs read 0 immediately and lock is re-acquired 3 words after release.
